// File: rtl/rr_arbiter4_ctrl.sv
// Four-requester round-robin arbiter with a bounded hold time per grant.
// Winner is kept as a 2-bit index; the one-hot grant is its registered decode.
module rr_arbiter4_ctrl #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CW       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid
);

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    localparam logic [CW-1:0] MaxHoldC = CW'(MAX_HOLD);
    localparam logic [CW-1:0] OneC     = CW'(1);

    state_e        r_state;
    state_e        w_state_nxt;
    logic [1:0]    r_ptr;
    logic [1:0]    w_ptr_nxt;
    logic [CW-1:0] r_hold_cnt;
    logic [CW-1:0] w_hold_cnt_nxt;
    logic [1:0]    r_gnt_id;
    logic [1:0]    w_gnt_id_nxt;
    logic          r_gnt_valid;
    logic          w_gnt_valid_nxt;
    logic [3:0]    r_gnt;
    logic [3:0]    w_gnt_nxt;

    // Search start: the stored pointer when idle; one past the grantee while granting,
    // which is exactly the pointer value that a release or timeout would install.
    logic [1:0]    w_search_base;
    logic          w_found;
    logic [1:0]    w_winner;

    assign w_search_base = (r_state == StGrant) ? (r_gnt_id + 2'd1) : r_ptr;

    always_comb begin
        logic [1:0] w_idx;
        w_found  = 1'b0;
        w_winner = w_search_base;
        w_idx    = w_search_base;
        for (int k = 0; k < 4; k++) begin
            w_idx = w_search_base + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_gnt_id_nxt    = r_gnt_id;
        w_gnt_valid_nxt = r_gnt_valid;

        unique case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_state_nxt     = StGrant;
                    w_gnt_id_nxt    = w_winner;
                    w_gnt_valid_nxt = 1'b1;
                    w_hold_cnt_nxt  = OneC;
                end
            end
            StGrant: begin
                if (!req[r_gnt_id]) begin
                    w_ptr_nxt = r_gnt_id + 2'd1;
                    if (w_found) begin
                        w_gnt_id_nxt   = w_winner;
                        w_hold_cnt_nxt = OneC;
                    end else begin
                        w_state_nxt     = StIdle;
                        w_gnt_valid_nxt = 1'b0;
                        w_hold_cnt_nxt  = '0;
                    end
                end else if (r_hold_cnt == MaxHoldC) begin
                    // The grantee still requests, so the search always finds someone;
                    // it is reached last and so re-granted only when nobody else waits.
                    w_ptr_nxt      = r_gnt_id + 2'd1;
                    w_gnt_id_nxt   = w_winner;
                    w_hold_cnt_nxt = OneC;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + OneC;
                end
            end
            default: begin
                w_state_nxt     = StIdle;
                w_gnt_valid_nxt = 1'b0;
                w_hold_cnt_nxt  = '0;
            end
        endcase

        w_gnt_nxt = w_gnt_valid_nxt ? (4'b0001 << w_gnt_id_nxt) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_ptr       <= 2'd0;
            r_hold_cnt  <= '0;
            r_gnt_id    <= 2'd0;
            r_gnt_valid <= 1'b0;
            r_gnt       <= 4'b0000;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_gnt       <= w_gnt_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;

endmodule

// File: doc/rr_arbiter4_ctrl.md
Name: rr_arbiter4_ctrl

Overview:
Four-requester round-robin arbiter that shares one resource, such as a bus or a memory port. It encodes the winner as a 2-bit index, and a 2-to-4 decode of that index drives a one-hot grant vector. A hold counter limits how long any one requester keeps the grant. The block sits between requesting masters and the shared resource select lines.

Parameters:
MAX_HOLD, 4, maximum consecutive grant cycles to one requester while others wait; legal range 1..255.
CW, 8, width of the hold counter; must satisfy 2**CW > MAX_HOLD.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req  input  4  request lines; req[i] high = requester i wants the resource
gnt  output 4  one-hot grant, registered; all zero when idle
gnt_id  output 2  binary index of the current grantee; valid only when gnt_valid=1
gnt_valid  output 1  high when any gnt bit is high

Behaviour:
- Reset (rst=1 at a rising edge):
  - gnt=4'b0000, gnt_id=2'b00, gnt_valid=0.
  - State=IDLE, pointer ptr=0, hold_cnt=0.
  - rst overrides all other inputs. Reset asserted mid-grant drops gnt at that same edge.
- Invariants:
  - gnt is always the 2-to-4 decode of gnt_id, gated by gnt_valid.
  - At most one gnt bit is high.
  - All outputs are registered; none is combinational from req.
- Round-robin search:
  - Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - The first index with req high wins.
- State IDLE:
  - If any req bit is high at an edge, go to GRANT at that edge.
  - gnt_id=winner, gnt_valid=1, hold_cnt=1.
  - Latency is 1 cycle from req sampled high to gnt high.
  - If req=0, stay in IDLE with outputs unchanged.
- State GRANT, with current grantee g=gnt_id. Evaluate in this order at each edge:
  - a) req[g]=0 (release): ptr=g+1 mod 4, then re-run the search on the current req with the new ptr.
    - Any winner: stay in GRANT, new gnt_id, hold_cnt=1. There is no idle bubble.
    - No winner: go to IDLE, gnt=0.
  - b) req[g]=1 and hold_cnt==MAX_HOLD (timeout): ptr=g+1 mod 4 and re-run the search.
    - g itself is searched last.
    - If only g is requesting, g is re-granted and hold_cnt=1. gnt stays high continuously.
  - c) Otherwise: hold, hold_cnt=hold_cnt+1.
- Requester deassert: gnt[g] remains high for the one cycle in which req[g] is sampled low, then moves or clears at that edge.
- Simultaneous release by g and a new request from another requester at the same edge: the new request is eligible in that same search.
- Request changes by non-granted requesters never disturb an active grant before release or timeout.
- hold_cnt never exceeds MAX_HOLD. With MAX_HOLD=1, the grant rotates every cycle whenever multiple requesters are active.
- X on req is not permitted after reset; the bench must drive known values.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt=0000, gnt_valid=0 throughout. First edge with rst=0 -> next cycle gnt=0001, gnt_id=0.
- Single requester: req=0100 from idle -> gnt=0100 one cycle later. Hold req for 10 cycles with MAX_HOLD=4 -> gnt stays 0100 continuously. Drop req -> gnt=0000 one cycle later.
- Rotation: req=1111 held, MAX_HOLD=4 -> gnt sequence 0001x4, 0010x4, 0100x4, 1000x4, 0001..., with no zero cycles between grants.
- Early release handover: req=0011, grant to 0. Drop req[0] after 2 grant cycles -> gnt=0010 at the next edge, hold_cnt restarts at 1.
- Pointer fairness: after requester 3 releases (ptr=0), assert req=1010 -> grant goes to 1, not 3. After 1 releases with req=1000 -> grant to 3.
- Reset mid-grant: gnt=0100 with hold_cnt=2, assert rst for one cycle -> gnt=0000 and ptr=0. Resume with req=0110 -> grant to 1.
